// File: rtl/proc_core_p.sv
// proc_core_p - parametrised multicycle processor core.
//
// A single controller plus datapath. Each instruction is fetched over a
// valid/ack instruction port and then executed. Loads and stores take an
// extra MEM phase over a valid/ack data port. Both ports tolerate any
// number of wait states. fetch_enable_i is honoured only at instruction
// boundaries. HALT parks the core until reset.
//
// Parameters: DATA_W (datapath/imm width), NREGS (register count, power of
// two), PC_W (program counter width, <= DATA_W).
// Instruction word: {op[3:0], dst[RW-1:0], src[RW-1:0], imm[DATA_W-1:0]}.
//
// Ports:
//   clk, rst (async, active-low)
//   fetch_enable_i                          gate for starting the next fetch
//   imem_req_o/addr_o/ack_i/rdata_i          instruction fetch handshake
//   dmem_req_o/we_o/addr_o/wdata_o/ack_i/rdata_i  data access handshake
//   cmp_flag_o                              compare flag used by BRT
//   halted_o                                core is parked in HALTED
//   retire_cnt_o                            retired-instruction count, only
//                                           when PROC_CORE_RETIRE_CNT_EN is
//                                           defined
module proc_core_p #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4,
   parameter int PC_W   = 8,
   localparam int RW      = $clog2(NREGS),
   localparam int INSTR_W = 4 + 2*RW + DATA_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_enable_i,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               dmem_req_o,
   output logic               dmem_we_o,
   output logic [DATA_W-1:0]  dmem_addr_o,
   output logic [DATA_W-1:0]  dmem_wdata_o,
   input  logic               dmem_ack_i,
   input  logic [DATA_W-1:0]  dmem_rdata_i,
   output logic               cmp_flag_o,
   output logic               halted_o
`ifdef PROC_CORE_RETIRE_CNT_EN
   ,
   output logic [31:0]        retire_cnt_o
`endif
);

   // state  | meaning
   // IDLE   | between instructions, waiting for fetch_enable_i
   // FETCH  | instruction request outstanding at pc
   // EXEC   | execute latched instruction
   // MEM    | load/store request outstanding
   // HALTED | parked after HALT, left only through reset
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_LD     = 4'd1;
   localparam logic [3:0] OP_ST     = 4'd2;
   localparam logic [3:0] OP_ADD    = 4'd3;
   localparam logic [3:0] OP_ADDI   = 4'd4;
   localparam logic [3:0] OP_AND    = 4'd5;
   localparam logic [3:0] OP_CMPLT  = 4'd6;
   localparam logic [3:0] OP_CMPEQ  = 4'd7;
   localparam logic [3:0] OP_CMPEQI = 4'd8;
   localparam logic [3:0] OP_SHR    = 4'd9;
   localparam logic [3:0] OP_SHL    = 4'd10;
   localparam logic [3:0] OP_INV    = 4'd11;
   localparam logic [3:0] OP_MVI    = 4'd12;
   localparam logic [3:0] OP_BRT    = 4'd13;
   localparam logic [3:0] OP_JMP    = 4'd14;
   localparam logic [3:0] OP_HALT   = 4'd15;

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   logic [2:0]         state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               cf_q, cf_d;
   logic [INSTR_W-1:0] ir_q;
   logic [DATA_W-1:0]  regs_q [NREGS];

   logic [3:0]         op;
   logic [RW-1:0]      dst;
   logic [RW-1:0]      src;
   logic [DATA_W-1:0]  imm;
   logic [PC_W-1:0]    imm_pc;
   logic [PC_W-1:0]    pc_inc;
   logic [DATA_W-1:0]  rd_val;
   logic [DATA_W-1:0]  rs_val;
   logic               is_mem;

   logic               wr_en;
   logic [DATA_W-1:0]  wr_data;

   assign op     = ir_q[INSTR_W-1 -: 4];
   assign dst    = ir_q[DATA_W+RW +: RW];
   assign src    = ir_q[DATA_W +: RW];
   assign imm    = ir_q[DATA_W-1:0];
   assign imm_pc = imm[PC_W-1:0];
   assign pc_inc = pc_q + PC_ONE;
   assign rd_val = regs_q[dst];
   assign rs_val = regs_q[src];
   assign is_mem = (op == OP_LD) || (op == OP_ST);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cf_d    = cf_q;
      wr_en   = 1'b0;
      wr_data = '0;
      case (state_q)
         S_IDLE: begin
            if (fetch_enable_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            // the fetch completes even if fetch_enable_i falls in the same cycle
            if (imem_ack_i) state_d = S_EXEC;
         end
         S_EXEC: begin
            if (is_mem) begin
               state_d = S_MEM;
            end else if (op == OP_HALT) begin
               state_d = S_HALTED;
            end else begin
               pc_d    = pc_inc;
               state_d = fetch_enable_i ? S_FETCH : S_IDLE;
               case (op)
                  OP_ADD:    begin wr_en = 1'b1; wr_data = rd_val + rs_val; end
                  OP_ADDI:   begin wr_en = 1'b1; wr_data = rd_val + imm;    end
                  OP_AND:    begin wr_en = 1'b1; wr_data = rd_val & rs_val; end
                  OP_CMPLT:  cf_d = (rd_val < rs_val);
                  OP_CMPEQ:  cf_d = (rd_val == rs_val);
                  OP_CMPEQI: cf_d = (rd_val == imm);
                  OP_SHR:    begin wr_en = 1'b1; wr_data = rd_val >> 1;     end
                  OP_SHL:    begin wr_en = 1'b1; wr_data = rd_val << 1;     end
                  OP_INV:    begin wr_en = 1'b1; wr_data = ~rd_val;         end
                  OP_MVI:    begin wr_en = 1'b1; wr_data = imm;             end
                  OP_BRT:    if (cf_q) pc_d = imm_pc;
                  OP_JMP:    pc_d = imm_pc;
                  default:   ;
               endcase
            end
         end
         S_MEM: begin
            if (dmem_ack_i) begin
               pc_d    = pc_inc;
               state_d = fetch_enable_i ? S_FETCH : S_IDLE;
               if (op == OP_LD) begin
                  wr_en   = 1'b1;
                  wr_data = dmem_rdata_i;
               end
            end
         end
         S_HALTED: ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cf_q    <= 1'b0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cf_q    <= cf_d;
         if (state_q == S_FETCH && imem_ack_i) ir_q <= imem_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[dst] <= wr_data;
      end
   end

   // Data-port fields come straight from the latched instruction and the
   // register file, neither of which can change while MEM waits for ack.
   assign imem_req_o   = (state_q == S_FETCH);
   assign imem_addr_o  = pc_q;
   assign dmem_req_o   = (state_q == S_MEM);
   assign dmem_we_o    = (state_q == S_MEM) && (op == OP_ST);
   assign dmem_addr_o  = imm;
   assign dmem_wdata_o = rs_val;
   assign cmp_flag_o   = cf_q;
   assign halted_o     = (state_q == S_HALTED);

`ifdef PROC_CORE_RETIRE_CNT_EN
   logic        retire;
   logic [31:0] retire_cnt_q;

   // HALT counts as retired on entry to HALTED, loads/stores on their ack
   assign retire = ((state_q == S_EXEC) && !is_mem) ||
                   ((state_q == S_MEM) && dmem_ack_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) retire_cnt_q <= '0;
      else if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;
   end

   assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_proc_core_p.sv
module tb_proc_core_p;

   logic        clk;
   logic        rst;
   logic        fetch_enable_i;
   logic        imem_req_o;
   logic [7:0]  imem_addr_o;
   logic        imem_ack_i;
   logic [15:0] imem_rdata_i;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [7:0]  dmem_addr_o;
   logic [7:0]  dmem_wdata_o;
   logic        dmem_ack_i;
   logic [7:0]  dmem_rdata_i;
   logic        cmp_flag_o;
   logic        halted_o;
`ifdef PROC_CORE_RETIRE_CNT_EN
   logic [31:0] retire_cnt_o;
`endif

   proc_core_p dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_enable_i (fetch_enable_i),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_ack_i     (imem_ack_i),
      .imem_rdata_i   (imem_rdata_i),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_ack_i     (dmem_ack_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .cmp_flag_o     (cmp_flag_o),
      .halted_o       (halted_o)
`ifdef PROC_CORE_RETIRE_CNT_EN
      ,
      .retire_cnt_o   (retire_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // program image, data memory as seen by the reference model, and the
   // store data actually driven by the core
   logic [15:0] prog    [256];
   logic [7:0]  dmem_m  [256];
   logic [7:0]  obs_mem [256];

   // instruction-level reference model
   logic [7:0]  m_regs [4];
   logic        m_cf;
   logic [7:0]  m_pc;
   logic        m_halt;
   int          m_retired;
   logic        m_pend;
   logic        m_we;
   logic [7:0]  m_addr;
   logic [7:0]  m_wdata;
   int          m_dst;
   int          exp_lat;
   int          last_lat;

   int imem_wait_cfg;
   int dmem_wait_cfg;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int cfg);
      return (cfg < 0) ? int'($urandom_range(3, 0)) : cfg;
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
   endtask

   task automatic emit(input logic [7:0] a, input logic [3:0] op, input int d,
                       input int s, input logic [7:0] imm);
      prog[a] = {op, 2'(d), 2'(s), imm};
   endtask

   task automatic model_exec(input logic [15:0] w, input int iw);
      logic [3:0] op;
      int         d, s;
      logic [7:0] imm;
      op  = w[15:12];
      d   = int'(w[11:10]);
      s   = int'(w[9:8]);
      imm = w[7:0];
      exp_lat += 2 + iw;
      case (op)
         4'd1, 4'd2: begin
            m_pend  = 1'b1;
            m_we    = (op == 4'd2);
            m_addr  = imm;
            m_wdata = m_regs[s];
            m_dst   = d;
         end
         4'd15: begin
            m_halt = 1'b1;
            m_retired++;
         end
         default: begin
            m_retired++;
            m_pc = m_pc + 8'd1;
            case (op)
               4'd3:  m_regs[d] = m_regs[d] + m_regs[s];
               4'd4:  m_regs[d] = m_regs[d] + imm;
               4'd5:  m_regs[d] = m_regs[d] & m_regs[s];
               4'd6:  m_cf = (m_regs[d] < m_regs[s]);
               4'd7:  m_cf = (m_regs[d] == m_regs[s]);
               4'd8:  m_cf = (m_regs[d] == imm);
               4'd9:  m_regs[d] = m_regs[d] >> 1;
               4'd10: m_regs[d] = m_regs[d] << 1;
               4'd11: m_regs[d] = ~m_regs[d];
               4'd12: m_regs[d] = imm;
               4'd13: if (m_cf) m_pc = imm;
               4'd14: m_pc = imm;
               default: ;
            endcase
         end
      endcase
   endtask

   task automatic model_mem_done(input logic [7:0] rdata, input int dw);
      if (m_we) dmem_m[m_addr] = m_wdata;
      else      m_regs[m_dst] = rdata;
      m_pend = 1'b0;
      m_pc   = m_pc + 8'd1;
      m_retired++;
      exp_lat += 1 + dw;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      fetch_enable_i = 1'b0;
      imem_ack_i     = 1'b0;
      dmem_ack_i     = 1'b0;
      imem_rdata_i   = '0;
      dmem_rdata_i   = '0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_cf = 1'b0; m_pc = 8'h00; m_halt = 1'b0; m_retired = 0; m_pend = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_imem_req",  imem_req_o,   0);
      chk("rst_imem_addr", imem_addr_o,  0);
      chk("rst_dmem_req",  dmem_req_o,   0);
      chk("rst_dmem_we",   dmem_we_o,    0);
      chk("rst_dmem_addr", dmem_addr_o,  0);
      chk("rst_dmem_wdat", dmem_wdata_o, 0);
      chk("rst_cmp_flag",  cmp_flag_o,   0);
      chk("rst_halted",    halted_o,     0);
`ifdef PROC_CORE_RETIRE_CNT_EN
      chk("rst_retire",    retire_cnt_o, 0);
`endif
      rst = 1'b1;
   endtask

   task automatic post_halt();
      chk("halt_pc",  imem_addr_o, m_pc);
      chk("halt_cf",  cmp_flag_o,  m_cf);
`ifdef PROC_CORE_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt_o, m_retired);
`endif
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("halt_stays",   halted_o,   1);
         chk("halt_no_ireq", imem_req_o, 0);
         chk("halt_no_dreq", dmem_req_o, 0);
         fetch_enable_i = ~fetch_enable_i;
         imem_ack_i = 1'b1;
         dmem_ack_i = 1'b1;
      end
      imem_ack_i = 1'b0;
      dmem_ack_i = 1'b0;
   endtask

   // Drives both memory ports cycle by cycle and checks the core against the
   // model until it halts or the cycle budget runs out.
   task automatic run(input int max_cyc, input bit gate_test, input bit chk_lat,
                      input bit rst_test);
      int cyc, start, ireq_n, dreq_n, iw, dw, gate_st, idle_n;
      bit done, rst_hit;
      cyc = 0; start = -1; ireq_n = 0; dreq_n = 0; gate_st = 0; idle_n = 0;
      done = 1'b0; rst_hit = 1'b0;
      iw = pick(imem_wait_cfg);
      dw = pick(dmem_wait_cfg);
      exp_lat = 0;
      fetch_enable_i = 1'b1;
      while (!done && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         imem_ack_i = 1'b0;
         dmem_ack_i = 1'b0;
         if (halted_o) begin
            chk("halted_when_model", halted_o, m_halt);
            last_lat = cyc - start;
            if (chk_lat) chk("latency", last_lat, exp_lat);
            done = 1'b1;
         end else begin
            if (gate_st == 2) begin
               chk("gate_idle_ireq", imem_req_o, 0);
               idle_n++;
               if (idle_n == 3) begin
                  fetch_enable_i = 1'b1;
                  gate_st = 3;
               end
            end
            if (imem_req_o) begin
               if (start < 0) start = cyc;
               chk("fetch_addr", imem_addr_o, m_pc);
               if (ireq_n == 0) chk("fetch_cf", cmp_flag_o, m_cf);
               if (ireq_n == iw) begin
                  imem_ack_i   = 1'b1;
                  imem_rdata_i = prog[imem_addr_o];
                  model_exec(prog[m_pc], iw);
                  ireq_n = 0;
                  iw = pick(imem_wait_cfg);
               end else begin
                  ireq_n++;
               end
            end else begin
               imem_ack_i   = 1'($urandom_range(1, 0));
               imem_rdata_i = 16'($urandom);
            end
            if (dmem_req_o) begin
               if (rst_test && dreq_n == 2) begin
                  #2 rst = 1'b0;
                  #1;
                  chk("rstmid_dmem_req", dmem_req_o, 0);
                  chk("rstmid_imem_req", imem_req_o, 0);
                  chk("rstmid_cf",       cmp_flag_o, 0);
                  chk("rstmid_pc",       imem_addr_o, 0);
`ifdef PROC_CORE_RETIRE_CNT_EN
                  chk("rstmid_retire",   retire_cnt_o, 0);
`endif
                  rst_hit = 1'b1;
                  done = 1'b1;
                  break;
               end
               chk("dmem_req_expected", dmem_req_o, m_pend);
               chk("dmem_we",    dmem_we_o,    m_we);
               chk("dmem_addr",  dmem_addr_o,  m_addr);
               if (m_we) chk("dmem_wdata", dmem_wdata_o, m_wdata);
               if (gate_test && gate_st == 0 && !dmem_we_o) begin
                  fetch_enable_i = 1'b0;
                  gate_st = 1;
               end
               if (dreq_n == dw) begin
                  dmem_ack_i   = 1'b1;
                  dmem_rdata_i = m_we ? 8'($urandom) : dmem_m[m_addr];
                  if (dmem_we_o) obs_mem[dmem_addr_o] = dmem_wdata_o;
                  model_mem_done(dmem_rdata_i, dw);
                  dreq_n = 0;
                  dw = pick(dmem_wait_cfg);
                  if (gate_st == 1) gate_st = 2;
               end else begin
                  dreq_n++;
               end
            end else begin
               dmem_ack_i   = 1'($urandom_range(1, 0));
               dmem_rdata_i = 8'($urandom);
            end
         end
      end
      if (!done) chk("halt_reached", halted_o, 1);
      if (done && !rst_hit) post_halt();
   endtask

   task automatic emit_dump(input logic [7:0] a);
      for (int i = 0; i < 4; i++) emit(a + 8'(i), 4'd2, 0, i, 8'hF0 + 8'(i));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         dmem_m[i]  = 8'($urandom);
         obs_mem[i] = 8'h00;
      end
      imem_wait_cfg = 0;
      dmem_wait_cfg = 0;

      // basic ALU, zero-wait: six cycles to HALTED, pc stays on the HALT
      do_reset();
      clear_prog();
      emit(0, 4'd12, 1, 0, 8'h05);
      emit(1, 4'd4,  1, 0, 8'hFE);
      emit(2, 4'd15, 0, 0, 8'h00);
      run(200, 0, 1, 0);
      chk("alu_halt_lat", last_lat, 6);
      chk("alu_halt_pc",  imem_addr_o, 2);

      // ALU results made visible through stores, including ADDI wrap
      do_reset();
      clear_prog();
      emit(0, 4'd12, 1, 0, 8'h05);
      emit(1, 4'd4,  1, 0, 8'hFE);
      emit(2, 4'd2,  0, 1, 8'h80);
      emit(3, 4'd12, 2, 0, 8'h01);
      emit(4, 4'd4,  2, 0, 8'hFF);
      emit(5, 4'd2,  0, 2, 8'h81);
      emit(6, 4'd15, 0, 0, 8'h00);
      run(200, 0, 1, 0);
      chk("alu_r1",    obs_mem[8'h80], 8'h03);
      chk("addi_wrap", obs_mem[8'h81], 8'h00);

      // data-port wait states
      do_reset();
      clear_prog();
      dmem_wait_cfg = 3;
      emit(0, 4'd12, 2, 0, 8'hA5);
      emit(1, 4'd2,  0, 2, 8'h40);
      emit(2, 4'd1,  3, 0, 8'h40);
      emit(3, 4'd2,  0, 3, 8'h41);
      emit(4, 4'd15, 0, 0, 8'h00);
      run(300, 0, 1, 0);
      chk("ld_after_st", obs_mem[8'h41], 8'hA5);
      dmem_wait_cfg = 0;

      // branch taken
      do_reset();
      clear_prog();
      emit(0, 4'd8,  0, 0, 8'h00);
      emit(1, 4'd13, 0, 0, 8'h10);
      emit(2, 4'd0,  0, 0, 8'h00);
      emit(8'h10, 4'd15, 0, 0, 8'h00);
      run(200, 0, 1, 0);
      chk("brt_taken_pc", imem_addr_o, 8'h10);

      // branch not taken
      do_reset();
      clear_prog();
      emit(0, 4'd12, 0, 0, 8'h01);
      emit(1, 4'd8,  0, 0, 8'h00);
      emit(2, 4'd13, 0, 0, 8'h10);
      emit(3, 4'd15, 0, 0, 8'h00);
      emit(8'h10, 4'd0, 0, 0, 8'h00);
      run(200, 0, 1, 0);
      chk("brt_not_taken_pc", imem_addr_o, 8'h03);

      // pc wraps from 0xFF to 0x00
      do_reset();
      clear_prog();
      emit(0, 4'd8,  0, 0, 8'h00);
      emit(1, 4'd13, 0, 0, 8'hFE);
      emit(2, 4'd15, 0, 0, 8'h00);
      emit(8'hFE, 4'd0,  0, 0, 8'h00);
      emit(8'hFF, 4'd12, 0, 0, 8'h01);
      run(300, 0, 1, 0);
      chk("pc_wrap_pc", imem_addr_o, 8'h02);

      // fetch gate dropped while a load waits for ack
      do_reset();
      clear_prog();
      dmem_wait_cfg = 2;
      emit(0, 4'd12, 1, 0, 8'h5A);
      emit(1, 4'd2,  0, 1, 8'h30);
      emit(2, 4'd1,  2, 0, 8'h30);
      emit(3, 4'd2,  0, 2, 8'h31);
      emit(4, 4'd15, 0, 0, 8'h00);
      run(300, 1, 0, 0);
      chk("gate_ld_data", obs_mem[8'h31], 8'h5A);
      dmem_wait_cfg = 0;

      // random forward-only programs with random wait states
      imem_wait_cfg = -1;
      dmem_wait_cfg = -1;
      for (int t = 0; t < 15; t++) begin
         int len;
         do_reset();
         clear_prog();
         len = int'($urandom_range(20, 8));
         for (int p = 0; p < len; p++) begin
            logic [3:0] op;
            logic [7:0] imm;
            op  = 4'($urandom_range(14, 0));
            imm = 8'($urandom);
            if (op == 4'd13 || op == 4'd14) imm = 8'($urandom_range(len, p + 1));
            emit(8'(p), op, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), imm);
         end
         emit_dump(8'(len));
         emit(8'(len + 4), 4'd15, 0, 0, 8'h00);
         run(3000, 0, 1, 0);
      end

      // reset while a load waits for ack, then confirm registers are cleared
      imem_wait_cfg = 0;
      dmem_wait_cfg = 6;
      do_reset();
      clear_prog();
      emit(0, 4'd12, 1, 0, 8'h33);
      emit(1, 4'd8,  0, 0, 8'h00);
      emit(2, 4'd1,  2, 0, 8'h20);
      emit(3, 4'd15, 0, 0, 8'h00);
      run(300, 0, 0, 1);
      dmem_wait_cfg = 0;
      do_reset();
      clear_prog();
      emit_dump(0);
      emit(4, 4'd15, 0, 0, 8'h00);
      run(300, 0, 1, 0);
      chk("rstmid_r1_cleared", obs_mem[8'hF1], 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/proc_core_p.md
Name: proc_core_p

Overview:
- Parametrised multicycle successor of the 8-bit processor top.
- Generalises data width and register-file depth.
- Adds valid/ack handshakes on both the instruction-memory and data-memory ports, so memories with wait states are supported.
- Adds branch and jump, a HALT state, and a fetch-enable gate that takes effect only at instruction boundaries.
- Sits at the top of the core; it replaces the fixed ifu/idu/eudp/euc composition with a single controller plus datapath.

Parameters:
- DATA_W, 8: datapath, register, data-address and immediate width.
- NREGS, 4: number of general registers; power of two, ≥2. RW = clog2(NREGS).
- PC_W, 8: program-counter and instruction-address width; must be ≤ DATA_W.
- Derived localparam INSTR_W = 4 + 2*RW + DATA_W.
- Instruction format is {op[3:0], dst[RW-1:0], src[RW-1:0], imm[DATA_W-1:0]}.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fetch_enable_i  in  1  allows fetch of the next instruction.
- imem_req_o  out  1  instruction fetch request.
- imem_addr_o  out  PC_W  fetch address (= pc).
- imem_ack_i  in  1  fetch complete; imem_rdata_i valid.
- imem_rdata_i  in  INSTR_W  instruction word.
- dmem_req_o  out  1  data access request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  DATA_W  data address (= imm).
- dmem_wdata_o  out  DATA_W  store data (= R[src]).
- dmem_ack_i  in  1  access complete; dmem_rdata_i valid on a load.
- dmem_rdata_i  in  DATA_W  load data.
- cmp_flag_o  out  1  current compare flag.
- halted_o  out  1  core is in the HALTED state.

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALTED. The state register uses the asynchronous, active-low reset.
- Reset values: state=IDLE, pc=0, all registers=0, cmp_flag=0. All outputs are 0, except imem_addr_o=0.
- IDLE:
  - fetch_enable_i=1 → FETCH on the next edge.
- FETCH:
  - imem_req_o=1; imem_addr_o=pc, held stable until ack.
  - imem_ack_i=1 (may arrive in the first FETCH cycle) → latch the instruction, go to EXEC.
  - No timeout.
- EXEC: executes the latched instruction. All arithmetic is modulo 2^DATA_W. Opcodes:
  - 0 NOP
  - 1 LD → MEM
  - 2 ST → MEM
  - 3 ADD: R[d] = R[d] + R[s]
  - 4 ADDI: R[d] = R[d] + imm
  - 5 AND: R[d] = R[d] & R[s]
  - 6 CMPLT: cf = (R[d] < R[s]), unsigned
  - 7 CMPEQ: cf = (R[d] == R[s])
  - 8 CMPEQI: cf = (R[d] == imm)
  - 9 SHR: R[d] = R[d] >> 1, logical
  - 10 SHL: R[d] = R[d] << 1
  - 11 INV: R[d] = ~R[d]
  - 12 MVI: R[d] = imm
  - 13 BRT: pc = cf ? imm[PC_W-1:0] : pc+1
  - 14 JMP: pc = imm[PC_W-1:0]
  - 15 HALT → HALTED; pc is not advanced.
- EXEC (non-memory, non-halt opcodes):
  - pc advances by +1 with wrap at 2^PC_W, unless a branch or jump is taken.
  - Next state: FETCH if fetch_enable_i=1, else IDLE.
  - Register file is written at most once per instruction; R0 is not hardwired.
- MEM:
  - dmem_req_o=1; dmem_we_o, dmem_addr_o and dmem_wdata_o held stable until dmem_ack_i.
  - On ack: LD writes R[d] = dmem_rdata_i; pc+1.
  - Next state: FETCH or IDLE, per fetch_enable_i sampled in the ack cycle.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU, branch and jump instructions: 2 cycles.
  - LD/ST: 3 cycles.
  - Each wait cycle adds 1.
- fetch_enable_i deasserted mid-instruction:
  - The in-flight instruction completes, including a pending handshake.
  - The core stops in IDLE at the instruction boundary.
  - No request is ever withdrawn before its ack.
- HALTED: halted_o=1, no requests issued, ignores fetch_enable_i; left only via rst.
- Ack inputs are ignored in states that do not issue the corresponding request.
- Reset asserted mid-handshake: the request drops asynchronously; no register or memory write occurs.
- Simultaneous imem_ack_i and a fetch_enable_i fall in FETCH: the instruction is still executed.

Optional Feature:
- Macro PROC_CORE_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt_o [31:0], reset to 0.
  - Increments by 1 on each retired instruction: the EXEC exit for non-memory opcodes, the MEM ack for LD/ST, and the HALT entry.
  - Wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/basic ALU (DATA_W=8, zero-wait imem): program MVI R1,0x05; ADDI R1,0xFE; HALT → R1=0x03, halted_o=1 after 6 cycles, pc=2.
- Data wait states (dmem_ack_i delayed 3 cycles): ST R2 (R2=0xA5) @0x40, then LD R3 @0x40 → dmem_req_o high 4 cycles each with address and data stable; R3=0xA5.
- Branch:
  - CMPEQI R0,0x00; BRT 0x10 → next imem_addr_o=0x10.
  - With R0=0x01 instead → next fetch address is pc+1.
- Fetch gate: drop fetch_enable_i while an LD waits for ack → the access completes and the core stops in IDLE with imem_req_o=0; reassert → fetch resumes at pc+1.
- Parametrised wrap (DATA_W=16, NREGS=8, PC_W=4): ADDI R7,0xFFFF on R7=0x0001 → R7=0x0000; a JMP-free run from pc=0xF wraps the fetch address to 0x0.
- Reset mid-handshake plus PROC_CORE_RETIRE_CNT_EN: assert rst during MEM → dmem_req_o=0 immediately, retire_cnt_o=0, registers=0.
